cnt_monitor: RTL and testbench
==============================

// Module: cnt_monitor
//
// PURPOSE
//   Downstream checker for the 4-bit free-running counter. Samples the counter
//   value every enabled cycle and checks that it only holds, steps +1, wraps
//   MAX->0, or restarts to 0. Reports wrap events, a saturating wrap tally,
//   stalls and illegal jumps. An illegal jump latches a sticky error.
//   Feeds status and debug logic.
//
// PARAMETERS
//   WIDTH        4   width of the monitored count; MAX = 2^WIDTH-1
//   WRAP_W       8   width of the wrap tally
//   STALL_LIMIT  16  consecutive held samples before stall asserts (>=2)
//
// PORTS
//   clk      in   1        rising-edge clock
//   reset    in   1        asynchronous, active-high; clears all state/outputs
//   en       in   1        sample enable; cnt is ignored when 0
//   clr      in   1        synchronous clear of monitor state (not of config)
//   cnt      in   WIDTH    counter value under observation
//   wrap     out  1        1-cycle pulse: a MAX->0 step was sampled
//   wraps    out  WRAP_W   number of wraps since reset/clr; saturates at all-ones
//   stall    out  1        level: cnt unchanged for >= STALL_LIMIT samples
//   err      out  1        sticky: illegal jump seen
//   err_val  out  WIDTH    cnt value that caused the first error
//
// BEHAVIOUR
//   - All outputs are registered. Every response appears on the cycle after
//     the sampling edge (1-cycle latency).
//   - Reset (async, any time, including mid-run): state=IDLE; prev=0;
//     hold_cnt=0; wrap=0; wraps=0; stall=0; err=0; err_val=0.
//   - Internal registers: prev[WIDTH], hold_cnt sized to count to STALL_LIMIT.
//   - State machine: IDLE, TRACK, ERROR.
//     IDLE : en=1 -> prev<=cnt, hold_cnt<=0, go TRACK. No checks on this first
//            sample.
//     TRACK: on en=1, classify cnt against prev; then prev<=cnt.
//       step  cnt==prev+1 and prev!=MAX -> hold_cnt<=0, stall<=0
//       wrap  prev==MAX and cnt==0      -> wrap<=1, wraps+1 (saturating),
//                                          hold_cnt<=0, stall<=0
//       rst0  cnt==0, prev!=0, prev!=MAX -> legal restart: hold_cnt<=0,
//                                          stall<=0, no wrap
//       hold  cnt==prev -> hold_cnt+1, saturating at STALL_LIMIT;
//             stall<=1 once hold_cnt+1 >= STALL_LIMIT
//       jump  anything else -> err<=1, err_val<=cnt, go ERROR
//     ERROR: ignores en/cnt. Freezes wraps, stall and err_val. err stays 1.
//   - en=0 in TRACK: no classification; prev, hold_cnt and stall hold; wrap=0.
//   - wrap is 0 in every cycle that is not a sampled wrap.
//   - clr=1 (any state): same clearing as reset but synchronous, and
//     state -> IDLE. clr has priority over en in the same cycle; the cnt
//     presented in that cycle is not sampled.
//   - Sample classified as hold with prev==0, cnt==0: this is hold, not rst0.
//   - wraps at all-ones plus another wrap: wraps stays all-ones; wrap still
//     pulses.
//
// TESTING
//   1 reset, en=1, cnt 0..15,0..15,0,1 -> wrap pulses exactly twice,
//     1 cycle after each 15->0 sample; wraps=2; err=0; stall=0
//   2 cnt held at 7 for 16 enabled samples after TRACK entry -> stall rises
//     1 cycle after the 16th hold sample; cnt=8 -> stall=0 next cycle
//   3 TRACK at prev=5, cnt=9 -> err=1, err_val=9; then cnt continues
//     -> all outputs frozen; clr -> err=0, wraps=0, state IDLE
//   4 prev=6, cnt=0 (restart) -> no err, no wrap; same with en=0 on an
//     illegal value -> ignored entirely
//   5 WRAP_W=2: run 5 full wraps -> wraps sequence 1,2,3,3,3; wrap pulses
//     5 times
//   6 assert reset asynchronously mid-stall and in ERROR -> outputs 0 before
//     the next clk edge; first post-reset sample is not checked

Source files
------------

// File: rtl/cnt_monitor.sv
// Checker for a free-running counter: flags wraps, stalls and illegal jumps.
// All outputs are registered and respond one cycle after the sampling edge.
module cnt_monitor #(
  parameter int WIDTH       = 4,
  parameter int WRAP_W      = 8,
  parameter int STALL_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [WIDTH-1:0]  cnt,
  output logic              wrap,
  output logic [WRAP_W-1:0] wraps,
  output logic              stall,
  output logic              err,
  output logic [WIDTH-1:0]  err_val
);

  localparam int HOLD_W = $clog2(STALL_LIMIT + 1);
  localparam logic [WIDTH-1:0]  MAX       = '1;
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(STALL_LIMIT);
  localparam logic [HOLD_W-1:0] HOLD_TRIP = HOLD_W'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                wrap_q, wrap_d;
  logic [WRAP_W-1:0]   wraps_q, wraps_d;
  logic                stall_q, stall_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    err_val_q, err_val_d;
  logic [WIDTH-1:0]    prev_inc;

  assign prev_inc = prev_q + WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    hold_d    = hold_q;
    wrap_d    = 1'b0;
    wraps_d   = wraps_q;
    stall_d   = stall_q;
    err_d     = err_q;
    err_val_d = err_val_q;

    if (clr) begin
      state_d   = IDLE;
      prev_d    = '0;
      hold_d    = '0;
      wraps_d   = '0;
      stall_d   = 1'b0;
      err_d     = 1'b0;
      err_val_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            prev_d  = cnt;
            hold_d  = '0;
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (en) begin
            prev_d = cnt;
            if (prev_q != MAX && cnt == prev_inc) begin
              hold_d  = '0;
              stall_d = 1'b0;
            end else if (prev_q == MAX && cnt == '0) begin
              wrap_d  = 1'b1;
              if (wraps_q != '1) wraps_d = wraps_q + WRAP_W'(1);
              hold_d  = '0;
              stall_d = 1'b0;
            end else if (cnt == '0 && prev_q != '0) begin
              hold_d  = '0;
              stall_d = 1'b0;
            end else if (cnt == prev_q) begin
              // Trip on the sample that brings the held count up to the limit.
              hold_d = (hold_q == HOLD_SAT) ? HOLD_SAT : hold_q + HOLD_W'(1);
              if (hold_q >= HOLD_TRIP) stall_d = 1'b1;
            end else begin
              err_d     = 1'b1;
              err_val_d = cnt;
              state_d   = ERROR;
            end
          end
        end
        ERROR: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      hold_q    <= '0;
      wrap_q    <= 1'b0;
      wraps_q   <= '0;
      stall_q   <= 1'b0;
      err_q     <= 1'b0;
      err_val_q <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      hold_q    <= hold_d;
      wrap_q    <= wrap_d;
      wraps_q   <= wraps_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
      err_val_q <= err_val_d;
    end
  end

  assign wrap    = wrap_q;
  assign wraps   = wraps_q;
  assign stall   = stall_q;
  assign err     = err_q;
  assign err_val = err_val_q;

endmodule

// File: tb/tb_cnt_monitor.sv
// Scoreboard bench for cnt_monitor: two instances (8-bit and 2-bit wrap tally)
// share stimulus; a sample-level reference model predicts every output cycle.
module tb_cnt_monitor;

  localparam int LIMIT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic [3:0] cnt;

  logic       wrap8, stall8, err8;
  logic [7:0] wraps8;
  logic [3:0] errv8;
  logic       wrap2, stall2, err2;
  logic [1:0] wraps2;
  logic [3:0] errv2;

  cnt_monitor #(.WIDTH(4), .WRAP_W(8), .STALL_LIMIT(LIMIT)) dut8 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .cnt(cnt),
    .wrap(wrap8), .wraps(wraps8), .stall(stall8), .err(err8), .err_val(errv8)
  );

  cnt_monitor #(.WIDTH(4), .WRAP_W(2), .STALL_LIMIT(LIMIT)) dut2 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .cnt(cnt),
    .wrap(wrap2), .wraps(wraps2), .stall(stall2), .err(err2), .err_val(errv2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wrap;
    logic [7:0] wraps8;
    logic [1:0] wraps2;
    logic       stall;
    logic       err;
    logic [3:0] err_val;
  } exp_t;

  exp_t expQ[$];
  int   vectors    = 0;
  int   checks     = 0;
  int   miscompares = 0;

  // Reference model: a sample history summarised as "have we started",
  // "are we halted", last sample, length of the current run of repeats
  // and the raw number of wraps seen.
  bit started, halted;
  int last, runLen, tally, mErr, mErrVal, mWrap;

  task automatic modelReset();
    started = 0; halted = 0; last = 0; runLen = 0; tally = 0;
    mErr = 0; mErrVal = 0; mWrap = 0;
  endtask

  task automatic modelStep(input bit e, input bit c, input int v);
    mWrap = 0;
    if (c) modelReset();
    else if (halted || !e) begin
    end else if (!started) begin
      started = 1; last = v; runLen = 0;
    end else begin
      if (v == last + 1) runLen = 0;
      else if (last == 15 && v == 0) begin mWrap = 1; tally++; runLen = 0; end
      else if (v == 0 && last != 0) runLen = 0;
      else if (v == last) runLen++;
      else begin mErr = 1; mErrVal = v; halted = 1; end
      last = v;
    end
  endtask

  function automatic exp_t modelOut();
    exp_t x;
    x.wrap    = mWrap[0];
    x.wraps8  = (tally > 255) ? 8'd255 : 8'(tally);
    x.wraps2  = (tally > 3) ? 2'd3 : 2'(tally);
    x.stall   = (runLen >= LIMIT);
    x.err     = mErr[0];
    x.err_val = 4'(mErrVal);
    return x;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit c, input int v);
    @(negedge clk);
    en = e; clr = c; cnt = 4'(v);
    modelStep(e, c, v);
    expQ.push_back(modelOut());
    vectors++;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wrap"},  wrap8,  0);
    checkOutput({tag, "_wraps"}, wraps8, 0);
    checkOutput({tag, "_stall"}, stall8, 0);
    checkOutput({tag, "_err"},   err8,   0);
    checkOutput({tag, "_errv"},  errv8,  0);
    checkOutput({tag, "_wraps2"}, wraps2, 0);
    checkOutput({tag, "_err2"},  err2,   0);
  endtask

  // Reset lands 3 time units after an edge; outputs must clear before the next.
  task automatic resetAsync(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1; en = 1'b0; clr = 1'b0;
    #1;
    checkAllZero(tag);
    modelReset();
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every edge with a pending prediction is compared one step later.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        x = expQ.pop_front();
        checkOutput("wrap",    wrap8,  x.wrap);
        checkOutput("wraps",   wraps8, x.wraps8);
        checkOutput("stall",   stall8, x.stall);
        checkOutput("err",     err8,   x.err);
        checkOutput("err_val", errv8,  x.err_val);
        checkOutput("wrap_w2", wrap2,  x.wrap);
        checkOutput("wraps_w2", wraps2, x.wraps2);
        checkOutput("stall_w2", stall2, x.stall);
      end
    end
  end

  initial begin
    int holdLeft;
    int drv;
    int r;
    bit e;
    bit c;
    reset = 1'b1; en = 1'b0; clr = 1'b0; cnt = '0;
    modelReset();
    #12;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Two full count passes: exactly two wraps.
    for (int p = 0; p < 2; p++)
      for (int v = 0; v < 16; v++) applyStimulus(1, 0, v);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);

    // Long hold then release.
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 17; i++) applyStimulus(1, 0, 7);
    applyStimulus(1, 0, 7);
    applyStimulus(1, 0, 8);
    applyStimulus(1, 0, 9);

    // Illegal jump, frozen error, clear.
    applyStimulus(1, 1, 0);
    for (int v = 0; v <= 5; v++) applyStimulus(1, 0, v);
    applyStimulus(1, 0, 9);
    applyStimulus(1, 0, 10);
    applyStimulus(1, 0, 15);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 3);
    applyStimulus(1, 0, 3);
    applyStimulus(1, 0, 4);

    // Legal restart and ignored illegal value while disabled.
    applyStimulus(1, 1, 0);
    for (int v = 0; v <= 6; v++) applyStimulus(1, 0, v);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 13);
    applyStimulus(1, 0, 2);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);

    // Five full wraps: the 2-bit tally must saturate at 3.
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    for (int w = 0; w < 5; w++)
      for (int v = 1; v <= 16; v++) applyStimulus(1, 0, v % 16);

    // Async reset mid-stall and in the error state.
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 3);
    resetAsync("rst_stall");
    applyStimulus(1, 0, 11);
    applyStimulus(1, 0, 12);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 9);
    applyStimulus(1, 0, 10);
    resetAsync("rst_err");
    applyStimulus(1, 0, 4);
    applyStimulus(1, 0, 5);

    // Randomized traffic: mostly legal steps, with hold bursts and rare faults.
    holdLeft = 0;
    drv = 5;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      e = ($urandom_range(0, 99) < 88);
      c = halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
      if (holdLeft > 0) holdLeft--;
      else if (r < 2) holdLeft = int'($urandom_range(14, 20));
      else if (r < 80) drv = (drv + 1) % 16;
      else if (r < 88) drv = drv;
      else if (r < 94) drv = 0;
      else drv = int'($urandom_range(0, 15));
      applyStimulus(e, c, drv);
    end

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      checks++;
      miscompares++;
      $display("[TB] FAIL drain: %0d predictions left, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
